// File: rtl/rk_tape_player.sv
// rk_tape_player: replays an RK tape image from SDRAM as a Manchester-coded cassette signal.
// Define RK_TAPE_TRAILER_EN to append two 0x00 bytes after the image before completion.
module rk_tape_player #(
    parameter int unsigned HALF_TICKS     = 640,
    parameter int unsigned PREAMBLE_BYTES = 256,
    parameter logic [7:0]  SYNC_BYTE      = 8'hE6
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic        stop,
    input  logic [24:0] base_addr,
    input  logic [24:0] file_size,
    output logic        rd_req,
    output logic [24:0] rd_addr,
    input  logic [7:0]  rd_data,
    input  logic        rd_ack,
    output logic        tape_out,
    output logic        busy,
    output logic        done
);
    localparam int unsigned   TW        = (HALF_TICKS > 1) ? $clog2(HALF_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(HALF_TICKS - 1);
    localparam logic [24:0]   PRE_LAST  = 25'(PREAMBLE_BYTES - 1);

`ifdef RK_TAPE_TRAILER_EN
    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, TRAIL, FINISH} state_t;
`else
    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, FINISH} state_t;
`endif

    state_t        state_q, state_d;
    logic [24:0]   size_q, index_q, byte_cnt_q;
    logic [TW-1:0] tick_q;
    logic          half_q;
    logic [2:0]    bit_q;
    logic [7:0]    shreg_q, nbuf_q;
    logic          nbuf_valid_q;
    logic          tape_q;

    logic          half_end, byte_end, have_more, ack_take;
    logic          stall, load, take_nbuf;
    logic [7:0]    load_val;

    assign have_more = (index_q != size_q);
    assign busy      = (state_q != IDLE) && (state_q != FINISH);
    assign done      = (state_q == FINISH);
    assign rd_req    = busy && !nbuf_valid_q && have_more;
    assign rd_addr   = base_addr + index_q;
    assign tape_out  = tape_q;
    assign ack_take  = rd_req && rd_ack;
    assign half_end  = ce && (tick_q == TICK_LAST);
    assign byte_end  = half_end && half_q && (bit_q == 3'd7);

    always_ff @(posedge clk_sys) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        load_val  = '0;
        take_nbuf = 1'b0;
        stall     = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = PREAMBLE;
            PREAMBLE: if (byte_end) begin
                load = 1'b1;
                if (byte_cnt_q == PRE_LAST) begin
                    load_val = SYNC_BYTE;
                    state_d  = SYNC;
                end
            end
            // SYNC and DATA share the next-byte decision: buffered byte, fetch stall, or end of image
            SYNC, DATA: if (byte_end) begin
                if (nbuf_valid_q) begin
                    load      = 1'b1;
                    take_nbuf = 1'b1;
                    load_val  = nbuf_q;
                    state_d   = DATA;
                end else if (have_more) begin
                    stall = 1'b1;
                end else begin
`ifdef RK_TAPE_TRAILER_EN
                    load    = 1'b1;
                    state_d = TRAIL;
`else
                    state_d = FINISH;
`endif
                end
            end
`ifdef RK_TAPE_TRAILER_EN
            TRAIL: if (byte_end) begin
                if (byte_cnt_q == 25'd1) state_d = FINISH;
                else                     load    = 1'b1;
            end
`endif
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d   = IDLE;
            load      = 1'b0;
            take_nbuf = 1'b0;
            stall     = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset || stop) begin
            size_q       <= '0;
            index_q      <= '0;
            byte_cnt_q   <= '0;
            tick_q       <= '0;
            half_q       <= 1'b0;
            bit_q        <= '0;
            shreg_q      <= '0;
            nbuf_q       <= '0;
            nbuf_valid_q <= 1'b0;
            tape_q       <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                size_q       <= file_size;
                index_q      <= '0;
                byte_cnt_q   <= '0;
                tick_q       <= '0;
                half_q       <= 1'b0;
                bit_q        <= '0;
                shreg_q      <= '0;
                nbuf_valid_q <= 1'b0;
                tape_q       <= 1'b1;
            end
        end else if (state_q == FINISH) begin
            tape_q <= 1'b0;
        end else begin
            if (ack_take) begin
                nbuf_q       <= rd_data;
                nbuf_valid_q <= 1'b1;
                index_q      <= index_q + 25'd1;
            end
            // a stall freezes the whole bit timer on the final half-cell edge
            if (ce && !stall) begin
                if (!half_end) begin
                    tick_q <= tick_q + TW'(1);
                end else begin
                    tick_q <= '0;
                    if (!half_q) begin
                        half_q <= 1'b1;
                        tape_q <= shreg_q[7];
                    end else begin
                        half_q <= 1'b0;
                        bit_q  <= bit_q + 3'd1;
                        if (bit_q != 3'd7) begin
                            shreg_q <= {shreg_q[6:0], 1'b0};
                            tape_q  <= ~shreg_q[6];
                        end else begin
                            if (state_d != state_q) byte_cnt_q <= '0;
                            else                    byte_cnt_q <= byte_cnt_q + 25'd1;
                            if (take_nbuf) nbuf_valid_q <= 1'b0;
                            if (load) begin
                                shreg_q <= load_val;
                                tape_q  <= ~load_val[7];
                            end else begin
                                tape_q <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_rk_tape_player.sv
// tb_rk_tape_player: scoreboard bench; expected per-cycle tape levels are queued by the
// stimulus and popped by a monitor while busy; a memory responder serves reads.
module tb_rk_tape_player;
    localparam int unsigned HT  = 2;
    localparam int unsigned PRE = 2;
`ifdef RK_TAPE_TRAILER_EN
    localparam int unsigned TRL = 2;
`else
    localparam int unsigned TRL = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1, ce = 1'b1, start = 1'b0, stop = 1'b0;
    logic [24:0] base_addr = 25'h0123400;
    logic [24:0] file_size = '0;
    logic        rd_req, rd_ack;
    logic [24:0] rd_addr;
    logic [7:0]  rd_data;
    logic        tape_out, busy, done;

    always #5 clk_sys = ~clk_sys;

    rk_tape_player #(.HALF_TICKS(HT), .PREAMBLE_BYTES(PRE), .SYNC_BYTE(8'hE6)) dut (
        .clk_sys(clk_sys), .reset(reset), .ce(ce), .start(start), .stop(stop),
        .base_addr(base_addr), .file_size(file_size), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_ack(rd_ack), .tape_out(tape_out), .busy(busy), .done(done)
    );

    int unsigned errors = 0, checks = 0;
    int unsigned cyc = 0, done_cnt = 0, done_cyc = 0, t0 = 0;
    bit          exp_q[$];
    bit          mon_en = 1'b0;
    bit          mon_e;
    logic [7:0]  img[4];
    int unsigned lat[4];
    int unsigned img_len = 0, rd_idx = 0, ri;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk_sys) cyc <= cyc + 1;

    // monitor: one expected level per busy cycle, done must land exactly when the queue drains
    always @(negedge clk_sys) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (mon_en) begin
                check("done_queue_drained", exp_q.size(), 0);
                check("done_tape_low", {31'b0, tape_out}, 0);
                check("done_busy_low", {31'b0, busy}, 0);
            end
        end else if (mon_en && busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("tape_extra_cycle", {31'b0, busy}, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tape_level", {31'b0, tape_out}, {31'b0, mon_e});
            end
        end
    end

    // memory responder
    initial begin
        rd_ack  = 1'b0;
        rd_data = '0;
        forever begin
            @(negedge clk_sys);
            if (rd_req === 1'b1) begin
                ri = rd_idx;
                if (ri >= img_len) begin
                    check("no_rd_req", {31'b0, rd_req}, 0);
                    rd_data = '0;
                end else begin
                    check("rd_addr", rd_addr, base_addr + 25'(ri));
                    repeat (lat[ri]) @(negedge clk_sys);
                    rd_data = img[ri];
                end
                rd_ack = 1'b1;
                rd_idx++;
                @(negedge clk_sys);
                rd_ack = 1'b0;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b);
        for (int unsigned i = 0; i < 8; i++) begin
            repeat (HT) exp_q.push_back(~b[7-i]);
            repeat (HT) exp_q.push_back(b[7-i]);
        end
    endtask

    task automatic push_file(input int unsigned n, input int unsigned stall0);
        exp_q.delete();
        for (int unsigned p = 0; p < PRE; p++) push_byte(8'h00);
        push_byte(8'hE6);
        for (int unsigned i = 0; i < n; i++) begin
            push_byte(img[i]);
            if (i == 0) repeat (stall0) exp_q.push_back(img[0][0]);
        end
        for (int unsigned t = 0; t < TRL; t++) push_byte(8'h00);
    endtask

    task automatic do_start(input logic [24:0] size);
        @(negedge clk_sys);
        file_size = size;
        start     = 1'b1;
        @(negedge clk_sys);
        start     = 1'b0;
        file_size = 25'h1FFFFFF;
        t0 = cyc;
        check("start_busy", {31'b0, busy}, 1);
        check("start_tape_high", {31'b0, tape_out}, 1);
    endtask

    task automatic wait_done(input int unsigned exp_cycles);
        int unsigned d0, waited;
        d0 = done_cnt;
        waited = 0;
        while (done_cnt == d0 && waited < 2000) begin
            @(negedge clk_sys); #1;
            waited++;
        end
        check("done_seen", done_cnt - d0, 1);
        check("done_latency", done_cyc - t0, exp_cycles);
        repeat (4) @(negedge clk_sys);
        #1;
        check("done_single_pulse", done_cnt - d0, 1);
        check("idle_after_done", {31'b0, busy}, 0);
    endtask

    task automatic setup(input int unsigned n, input logic [7:0] b0, input logic [7:0] b1,
                         input int unsigned l0, input int unsigned l1);
        img_len = n;
        rd_idx  = 0;
        img[0] = b0; img[1] = b1; img[2] = '0; img[3] = '0;
        lat[0] = l0; lat[1] = l1; lat[2] = 1; lat[3] = 1;
    endtask

    initial begin
        int unsigned d0, hi;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d0, hi;
        setup(0, 8'h00, 8'h00, 1, 1);
        repeat (3) @(negedge clk_sys);
        reset = 1'b0;
        check("rst_tape", {31'b0, tape_out}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_rd_req", {31'b0, rd_req}, 0);
        check("rst_rd_addr", rd_addr, base_addr);

        // empty image: preamble + sync only, no reads
        setup(0, 8'h00, 8'h00, 1, 1);
        push_file(0, 0);
        mon_en = 1'b1;
        do_start(25'd0);
        wait_done((PRE + 1 + 0 + TRL) * 16 * HT);

        // two bytes, fast memory; a start pulse mid-playback must be ignored
        setup(2, 8'hA5, 8'h3C, 1, 1);
        push_file(2, 0);
        do_start(25'd2);
        repeat (20) @(negedge clk_sys);
        start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        wait_done((PRE + 1 + 2 + TRL) * 16 * HT);

        // byte 1 acked late enough to stall the bit timer for 100 cycles
        setup(2, 8'hA5, 8'h3C, 1, 130);
        push_file(2, 100);
        do_start(25'd2);
        wait_done((PRE + 1 + 2 + TRL) * 16 * HT + 100);

        // reset during DATA with a read outstanding; the late ack must be ignored
        mon_en = 1'b0;
        setup(2, 8'hA5, 8'h3C, 1, 130);
        d0 = done_cnt;
        do_start(25'd2);
        repeat (110) @(negedge clk_sys);
        check("pre_reset_rd_req", {31'b0, rd_req}, 1);
        reset = 1'b1;
        @(negedge clk_sys);
        reset = 1'b0;
        check("reset_mid_tape", {31'b0, tape_out}, 0);
        check("reset_mid_busy", {31'b0, busy}, 0);
        check("reset_mid_rd_req", {31'b0, rd_req}, 0);
        hi = 0;
        repeat (130) begin
            @(negedge clk_sys);
            if (tape_out !== 1'b0 || busy !== 1'b0 || rd_req !== 1'b0) hi++;
        end
        check("reset_quiet_cycles", hi, 0);
        check("reset_rd_addr", rd_addr, base_addr);
        check("reset_no_done", done_cnt - d0, 0);

        // stop mid-preamble, then replay from the start
        setup(0, 8'h00, 8'h00, 1, 1);
        d0 = done_cnt;
        do_start(25'd0);
        repeat (10) @(negedge clk_sys);
        stop = 1'b1;
        @(negedge clk_sys);
        stop = 1'b0;
        check("stop_busy", {31'b0, busy}, 0);
        check("stop_tape", {31'b0, tape_out}, 0);
        check("stop_rd_req", {31'b0, rd_req}, 0);
        repeat (120) @(negedge clk_sys);
        check("stop_no_done", done_cnt - d0, 0);
        push_file(0, 0);
        mon_en = 1'b1;
        do_start(25'd0);
        wait_done((PRE + 1 + 0 + TRL) * 16 * HT);

        // single 0xFF byte (followed by the trailer when enabled)
        setup(1, 8'hFF, 8'h00, 1, 1);
        push_file(1, 0);
        do_start(25'd1);
        wait_done((PRE + 1 + 1 + TRL) * 16 * HT);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
